// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA timing generator.
//  - Frame geometry defaults (640x480 @ 25 MHz, 800x525 raster).
//  - Counter / coordinate types and the {hs, vs, active} bundle carried
//    through the alignment delay line.
package vga_timing_gen_pkg;

  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;

  localparam int H_ACTIVE_DEF = FRAME_WIDTH;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = FRAME_HEIGHT;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int CNT_W = 10;
  localparam int XY_W  = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [XY_W-1:0]  xy_t;

  // hs/vs are carried at pin level (polarity already applied).
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bundle_t;

  // Inclusive-low / exclusive-high window test on a raster counter.
  function automatic logic in_window(input cnt_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: fixed-depth delay line with asynchronous active-high reset.
//  clk   in   clock
//  rst   in   async active-high reset; every stage loads RST_VAL
//  din   in   WIDTH-bit input
//  dout  out  din delayed by DEPTH cycles (DEPTH == 0 is a plain wire)
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= {DEPTH{RST_VAL}};
      else     pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster generator.
//  CLOCK_25     in   pixel clock
//  reset        in   async active-high reset
//  color_in     in   [2]=R [1]=G [0]=B from the image generator
//  x, y         out  1-based active coordinates, 0 outside the active area
//  frame_start  out  high while the raster sits at (0,0), no delay
//  vga_hs/vs    out  syncs delayed to line up with the RGB pins
//  vga_blank_n  out  1 while RGB carries an active pixel
//  vga_r/g/b    out  color bits replicated to COLOR_BITS, 0 when blanked
// Pins show the pixel whose x/y were presented PIPE_DELAY+1 cycles earlier.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 0,
  parameter int   COLOR_BITS = 4
) (
  input  logic                  CLOCK_25,
  input  logic                  reset,
  input  logic [2:0]            color_in,
  output logic [XY_W-1:0]       x,
  output logic [XY_W-1:0]       y,
  output logic                  frame_start,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_blank_n,
  output logic [COLOR_BITS-1:0] vga_r,
  output logic [COLOR_BITS-1:0] vga_g,
  output logic [COLOR_BITS-1:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam sync_bundle_t BUNDLE_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0};

  // Raster counters
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == cnt_t'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == cnt_t'(V_TOTAL - 1)) ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Zero-latency raster decode
  logic active, hs_raw, vs_raw;

  assign active = in_window(h_cnt_q, 0, H_ACTIVE) && in_window(v_cnt_q, 0, V_ACTIVE);
  assign hs_raw = in_window(h_cnt_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = in_window(v_cnt_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);

  assign x           = active ? xy_t'(h_cnt_q) + xy_t'(1) : '0;
  assign y           = active ? xy_t'(v_cnt_q) + xy_t'(1) : '0;
  assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

  // Align sync/active with the image generator's pipeline
  sync_bundle_t raw_b, dly_b;

  assign raw_b.hs     = hs_raw ? SYNC_POL : ~SYNC_POL;
  assign raw_b.vs     = vs_raw ? SYNC_POL : ~SYNC_POL;
  assign raw_b.active = active;

  sync_delay_line #(
    .WIDTH  ($bits(sync_bundle_t)),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(BUNDLE_IDLE)
  ) u_sync_dly (
    .clk (CLOCK_25),
    .rst (reset),
    .din (raw_b),
    .dout(dly_b)
  );

  // Output register: delayed syncs plus color_in, blanked together
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic                  blank_n_q, blank_n_d;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    hs_d      = dly_b.hs;
    vs_d      = dly_b.vs;
    blank_n_d = dly_b.active;
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    // color_in is don't-care outside the active area, so gate it here
    if (dly_b.active) begin
      r_d = {COLOR_BITS{color_in[2]}};
      g_d = {COLOR_BITS{color_in[1]}};
      b_d = {COLOR_BITS{color_in[0]}};
    end
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (PIPE_DELAY=0) and a
// shrunken-raster instance (PIPE_DELAY=2) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst0, rst1;
  logic [2:0]  col0, col1;
  logic [11:0] x0, y0, x1, y1;
  logic        fs0, hs0, vs0, bn0, fs1, hs1, vs1, bn1;
  logic [3:0]  r0, g0, b0, r1, g1, b1;

  vga_timing_gen u_dut0 (
    .CLOCK_25(clk), .reset(rst0), .color_in(col0), .x(x0), .y(y0),
    .frame_start(fs0), .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bn0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIPE_DELAY(2)
  ) u_dut1 (
    .CLOCK_25(clk), .reset(rst1), .color_in(col1), .x(x1), .y(y1),
    .frame_start(fs1), .vga_hs(hs1), .vga_vs(vs1), .vga_blank_n(bn1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1)
  );

  int total = 0;
  int bad   = 0;
  int t0, t1;             // cycles since each instance left reset
  logic [2:0] pc0, pc1;   // color_in present during the previous cycle

  typedef struct {
    int          t;
    logic [2:0]  col;
    logic [11:0] x, y;
    logic        hs, bn;
    logic [3:0]  r, g, b;
  } vec_t;
  vec_t tab[11];

  task automatic chk(input string name, input int tt, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", name, tt, act, exp);
    end
  endtask

  task automatic step();
    pc0 = col0;
    pc1 = col1;
    @(posedge clk);
    #1;
    t0 = rst0 ? 0 : t0 + 1;
    t1 = rst1 ? 0 : t1 + 1;
  endtask

  // Reference: raster position is just elapsed cycles modulo the frame
  // geometry; the pins replay the pixel D+1 cycles back with the color
  // that was on color_in one cycle back.
  function automatic logic [39:0] model(input int ha, hf, hsw, hb, va, vf, vsw, vb, d, t,
                                        input logic [2:0] pc);
    int ht, vt, h, v, p, ph, pv;
    logic act, pact, fs, hs, vs;
    logic [11:0] ex, ey;
    logic [3:0] r, g, b;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    h   = t % ht;
    v   = (t / ht) % vt;
    act = (h < ha) && (v < va);
    ex  = act ? 12'(h + 1) : 12'd0;
    ey  = act ? 12'(v + 1) : 12'd0;
    fs  = (h == 0) && (v == 0);
    p   = t - d - 1;
    hs = 1'b1; vs = 1'b1; pact = 1'b0;
    if (p >= 0) begin
      ph   = p % ht;
      pv   = (p / ht) % vt;
      pact = (ph < ha) && (pv < va);
      hs   = !(ph >= ha + hf && ph < ha + hf + hsw);
      vs   = !(pv >= va + vf && pv < va + vf + vsw);
    end
    r = (pact && pc[2]) ? 4'hF : 4'h0;
    g = (pact && pc[1]) ? 4'hF : 4'h0;
    b = (pact && pc[0]) ? 4'hF : 4'h0;
    return {ex, ey, fs, hs, vs, pact, r, g, b};
  endfunction

  initial begin
    int ti, hs_cnt, hs_first, vs_cnt, g_cnt, g_blank, fs_n, last_fs;
    logic [11:0] ymax;
    logic [2:0] p1, p2, pat;

    //            t    col     x       y       hs    bn    r     g     b
    tab[0]  = '{  1, 3'b101, 12'd2,   12'd1, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
    tab[1]  = '{  2, 3'b010, 12'd3,   12'd1, 1'b1, 1'b1, 4'h0, 4'hF, 4'h0};
    tab[2]  = '{639, 3'b011, 12'd640, 12'd1, 1'b1, 1'b1, 4'h0, 4'hF, 4'hF};
    tab[3]  = '{640, 3'b111, 12'd0,   12'd0, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF};
    tab[4]  = '{641, 3'b111, 12'd0,   12'd0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[5]  = '{656, 3'b101, 12'd0,   12'd0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[6]  = '{657, 3'b101, 12'd0,   12'd0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[7]  = '{752, 3'b000, 12'd0,   12'd0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[8]  = '{753, 3'b000, 12'd0,   12'd0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[9]  = '{800, 3'b111, 12'd1,   12'd2, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
    tab[10] = '{801, 3'b110, 12'd2,   12'd2, 1'b1, 1'b1, 4'hF, 4'hF, 4'h0};

    ti = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; g_cnt = 0; g_blank = 0;
    fs_n = 0; last_fs = -1; ymax = '0; p1 = '0; p2 = '0;
    t0 = 0; t1 = 0; pc0 = '0; pc1 = '0;

    // Reset held for 5 cycles
    rst0 = 1'b1; rst1 = 1'b1; col0 = 3'b111; col1 = 3'b111;
    #5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("reset_pins0", i, 40'({hs0, vs0, bn0, r0, g0, b0}), 40'({1'b1, 1'b1, 1'b0, 12'h000}));
      chk("reset_pins1", i, 40'({hs1, vs1, bn1, r1, g1, b1}), 40'({1'b1, 1'b1, 1'b0, 12'h000}));
    end
    rst0 = 1'b0; rst1 = 1'b0; t0 = 0; t1 = 0;
    chk("release_fs_xy", 0, 40'({fs0, x0, y0}), 40'({1'b1, 12'd1, 12'd1}));

    for (int c = 0; c < 1900; c++) begin
      if (c == 1503) rst0 = 1'b0;
      if (c == 1799) rst1 = 1'b0;

      chk("model0", t0, {x0, y0, fs0, hs0, vs0, bn0, r0, g0, b0},
          model(640, 16, 96, 48, 480, 10, 2, 33, 0, t0, pc0));
      chk("model1", t1, {x1, y1, fs1, hs1, vs1, bn1, r1, g1, b1},
          model(16, 2, 4, 3, 8, 2, 2, 3, 2, t1, pc1));

      if (ti < 11 && tab[ti].t == t0 && !rst0) begin
        chk("table", t0, 40'({x0, y0, hs0, bn0, r0, g0, b0}),
            40'({tab[ti].x, tab[ti].y, tab[ti].hs, tab[ti].bn, tab[ti].r, tab[ti].g, tab[ti].b}));
        ti++;
      end

      if (c < 800 && hs0 == 1'b0) begin
        if (hs_cnt == 0) hs_first = c;
        hs_cnt++;
      end
      if (c < 750) begin
        if (vs1 == 1'b0) vs_cnt++;
        if (g1 != 4'h0) g_cnt++;
        if (g1 != 4'h0 && !bn1) g_blank++;
        if (y1 > ymax) ymax = y1;
      end
      if (fs1 && c < 1700) begin
        if (last_fs >= 0) chk("frame_period", c, 40'(c - last_fs), 40'd375);
        last_fs = c;
        fs_n++;
      end

      // Async reset in mid-line, inside hsync (big raster)
      if (c == 1500) begin
        chk("pre_rst0_hs", c, 40'(hs0), 40'd0);
        #2 rst0 = 1'b1;
        #1;
        chk("midline_rst0", c, 40'({hs0, vs0, bn0, r0, g0, b0, fs0, x0, y0}),
            40'({1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'd1, 12'd1}));
      end
      // Async reset inside both syncs (small raster)
      if (c == 1796) begin
        chk("pre_rst1_sync", c, 40'({hs1, vs1}), 40'd0);
        #2 rst1 = 1'b1;
        #1;
        chk("midsync_rst1", c, 40'({hs1, vs1, bn1, r1, g1, b1, fs1, x1, y1}),
            40'({1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'd1, 12'd1}));
      end

      if (ti < 11 && tab[ti].t == t0 + 1) col0 = tab[ti].col;
      else                                col0 = 3'($urandom_range(7, 0));

      // Image generator stand-in: green on x==1, registered twice
      pat = (x1 == 12'd1) ? 3'b010 : 3'b000;
      col1 = (c < 750) ? p2 : 3'($urandom_range(7, 0));
      p2 = p1;
      p1 = pat;

      step();
    end

    chk("hs_low_len",   0, 40'(hs_cnt),   40'd96);
    chk("hs_low_start", 0, 40'(hs_first), 40'd657);
    chk("vs_low_len",   0, 40'(vs_cnt),   40'd100);
    chk("green_count",  0, 40'(g_cnt),    40'd16);
    chk("green_blank",  0, 40'(g_blank),  40'd0);
    chk("y_max",        0, 40'(ymax),     40'd8);
    chk("frame_pulses", 0, 40'(fs_n),     40'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
